// File: rtl/gon_pkg.sv
// Shared widths, FSM encoding and ready_tag field helpers for the GON Y-bus gather path.
package gon_pkg;
  localparam int ID_LEN    = 5;
  localparam int ROW_LEN   = 4;
  localparam int VALUE_LEN = 32;
  localparam int TAG_W     = ROW_LEN + ID_LEN + 1;
  localparam int READY_BIT = ROW_LEN + ID_LEN;
  localparam int ROW_LSB   = ID_LEN;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] make_tag(input logic [ROW_LEN-1:0] row,
                                                input logic [ID_LEN-1:0]  col);
    make_tag = {1'b1, row, col};
  endfunction
endpackage

// File: rtl/gon_tag_counter.sv
// Row-major 2-D tag counter with a running linear write address (base + row*cols + col).
module gon_tag_counter
  import gon_pkg::*;
#(
  parameter int ADDR_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                advance,
  input  logic [ROW_LEN:0]    row_count,
  input  logic [ID_LEN:0]     col_count,
  input  logic [ADDR_LEN-1:0] base,
  output logic [ROW_LEN-1:0]  row,
  output logic [ID_LEN-1:0]   col,
  output logic [ADDR_LEN-1:0] addr,
  output logic                last
);
  logic [ROW_LEN-1:0]  row_q, row_d;
  logic [ID_LEN-1:0]   col_q, col_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [ROW_LEN:0]    rcnt_q, rcnt_d;
  logic [ID_LEN:0]     ccnt_q, ccnt_d;
  logic                row_last_s, col_last_s;

  assign row_last_s = ({1'b0, row_q} == (rcnt_q - (ROW_LEN+1)'(1)));
  assign col_last_s = ({1'b0, col_q} == (ccnt_q - (ID_LEN+1)'(1)));

  // Next-state: load the window on start, step one tag per accepted write.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    rcnt_d = rcnt_q;
    ccnt_d = ccnt_q;
    if (load) begin
      row_d  = {ROW_LEN{1'b0}};
      col_d  = {ID_LEN{1'b0}};
      addr_d = base;
      rcnt_d = row_count;
      ccnt_d = col_count;
    end else if (advance) begin
      addr_d = addr_q + ADDR_LEN'(1);
      if (col_last_s) begin
        col_d = {ID_LEN{1'b0}};
        row_d = row_q + ROW_LEN'(1);
      end else begin
        col_d = col_q + ID_LEN'(1);
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Counter and latched window registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= {ROW_LEN{1'b0}};
      col_q  <= {ID_LEN{1'b0}};
      addr_q <= {ADDR_LEN{1'b0}};
      rcnt_q <= {(ROW_LEN+1){1'b0}};
      ccnt_q <= {(ID_LEN+1){1'b0}};
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
      rcnt_q <= rcnt_d;
      ccnt_q <= ccnt_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign addr = addr_q;
  assign last = row_last_s & col_last_s;
endmodule

// File: rtl/gon_gather_sequencer.sv
// Request-side gather controller: sweeps a row/col tag window over the Y-bus and
// writes each returned value into the global buffer at a running linear address.
module gon_gather_sequencer
  import gon_pkg::*;
#(
  parameter int ADDR_LEN = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_LEN:0]     row_count,
  input  logic [ID_LEN:0]      col_count,
  input  logic [ADDR_LEN-1:0]  base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [TAG_W-1:0]     ready_tag,
  input  logic [VALUE_LEN:0]   enable_value,
  output logic                 wr_en,
  output logic [ADDR_LEN-1:0]  wr_addr,
  output logic [VALUE_LEN-1:0] wr_data,
  input  logic                 wr_ready
);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [WCNT_W-1:0]    wait_q, wait_d;
  logic [VALUE_LEN-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_en_q, wr_en_d;
  logic                 load_s, advance_s, last_s;
  logic [ROW_LEN-1:0]   row_s;
  logic [ID_LEN-1:0]    col_s;
  logic [ADDR_LEN-1:0]  addr_s;

  gon_tag_counter #(.ADDR_LEN(ADDR_LEN)) u_tag_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .advance   (advance_s),
    .row_count (row_count),
    .col_count (col_count),
    .base      (base_addr),
    .row       (row_s),
    .col       (col_s),
    .addr      (addr_s),
    .last      (last_s)
  );

  // Sweep FSM next-state and output decisions.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    data_d    = data_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s = 1'b1;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if ((row_count == {(ROW_LEN+1){1'b0}}) || (col_count == {(ID_LEN+1){1'b0}})) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        wait_d  = {WCNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Enable is checked first so it wins over a same-cycle timeout.
        if (enable_value[VALUE_LEN]) begin
          data_d  = enable_value[VALUE_LEN-1:0];
          wr_en_d = 1'b1;
          state_d = ST_WRITE;
        end else if (wait_q == WAIT_LAST) begin
          data_d  = {VALUE_LEN{1'b0}};
          err_d   = 1'b1;
          wr_en_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          wait_d = wait_q + WCNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          advance_s = 1'b1;
          if (last_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          wr_en_d = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= {WCNT_W{1'b0}};
      data_q  <= {VALUE_LEN{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign ready_tag   = ((state_q == ST_REQ) || (state_q == ST_WAIT)) ? make_tag(row_s, col_s)
                                                                      : {TAG_W{1'b0}};
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = addr_s;
  assign wr_data     = data_q;
endmodule

// File: tb/tb_gon_gather_sequencer.sv
// Directed bench for gon_gather_sequencer with a one-cycle-latency Y-bus responder.
module tb_gon_gather_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  row_count;
  logic [5:0]  col_count;
  logic [15:0] base_addr;
  logic        busy, done, timeout_err;
  logic [9:0]  ready_tag;
  logic [32:0] enable_value;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;

  int n_checks = 0;
  int n_errors = 0;

  // responder / sink knobs
  logic       mute_en;
  logic [8:0] mute_tag;
  int         stall_idx, stall_len, abort_cyc, restart_cyc;

  // per-sweep observations
  logic [15:0] wa[16];
  logic [31:0] wd[16];
  logic [8:0]  wt[16];
  int          rq[16];
  int          nwr, nreq, done_cyc, busy_cnt, rdy_cnt, max_run;
  logic        err_at_done;
  logic [15:0] snap_a;
  logic [31:0] snap_d;

  gon_gather_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .row_count(row_count), .col_count(col_count),
    .base_addr(base_addr), .busy(busy), .done(done), .timeout_err(timeout_err),
    .ready_tag(ready_tag), .enable_value(enable_value), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  task automatic clear_knobs();
    mute_en = 1'b0; mute_tag = 9'd0;
    stall_idx = -1; stall_len = 0; abort_cyc = -1; restart_cyc = -1;
  endtask

  // Cycle 0 carries the start pulse; outputs sampled at each negedge, inputs
  // for that same cycle applied right after.
  task automatic run_sweep(input int max_cyc);
    logic       rdy_prev, aborted;
    logic [8:0] prev_tag, cur_tag;
    int         run, stall_cnt;
    nwr = 0; nreq = 0; done_cyc = -1; busy_cnt = 0; rdy_cnt = 0; max_run = 0;
    err_at_done = 1'b0; rdy_prev = 1'b0; prev_tag = 9'd0; cur_tag = 9'd0;
    run = 0; stall_cnt = 0; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; enable_value = 33'd0; wr_ready = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = (c == restart_cyc) ? 1'b1 : 1'b0;
      if (c == restart_cyc) begin row_count = 5'd3; base_addr = 16'h1234; end
      if (c == abort_cyc) begin
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ready_tag, wr_en, busy, wr_addr} !== 28'd0) begin
          n_errors++;
          $display("FAIL reset_mid: tag=%h wr_en=%b busy=%b addr=%h, expected all 0",
                   ready_tag, wr_en, busy, wr_addr);
        end
        aborted = 1'b1;
        break;
      end
      // Y-bus: answer the tag seen last cycle, unless that tag is muted.
      if (rdy_prev && !(mute_en && prev_tag == mute_tag))
        enable_value = {1'b1, 24'h0, prev_tag[8:5], prev_tag[3:0]};
      else
        enable_value = 33'd0;
      wr_ready = 1'b1;
      if (wr_en && nwr == stall_idx && stall_cnt < stall_len) begin
        wr_ready = 1'b0;
        if (stall_cnt == 0) begin
          snap_a = wr_addr; snap_d = wr_data;
        end else begin
          n_checks++;
          if (wr_addr !== snap_a || wr_data !== snap_d) begin
            n_errors++;
            $display("FAIL stall_hold: addr=%h data=%h, expected %h %h", wr_addr, wr_data, snap_a, snap_d);
          end
        end
        n_checks++;
        if (ready_tag[9] !== 1'b0) begin
          n_errors++;
          $display("FAIL stall_no_req: ready=%b, expected 0", ready_tag[9]);
        end
        stall_cnt++;
      end
      if (busy) busy_cnt++;
      if (ready_tag[9]) begin
        rdy_cnt++;
        if (!rdy_prev || ready_tag[8:0] != prev_tag) begin
          run = 1;
          if (nreq < 16) rq[nreq] = c;
          nreq++;
        end else begin
          run++;
        end
        if (run > max_run) max_run = run;
        cur_tag = ready_tag[8:0];
      end
      rdy_prev = ready_tag[9];
      prev_tag = ready_tag[8:0];
      if (wr_en && wr_ready) begin
        if (nwr < 16) begin wa[nwr] = wr_addr; wd[nwr] = wr_data; wt[nwr] = cur_tag; end
        nwr++;
      end
      if (done) begin
        done_cyc = c; err_at_done = timeout_err;
        break;
      end
    end
    if (!aborted && done_cyc < 0) begin
      n_checks++; n_errors++;
      $display("FAIL sweep_bound: no done within %0d cycles", max_cyc);
    end
    @(negedge clk);
    start = 1'b0; enable_value = 33'd0; wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; row_count = 5'd0; col_count = 6'd0; base_addr = 16'd0;
    enable_value = 33'd0; wr_ready = 1'b1;
    clear_knobs();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, timeout_err, ready_tag, wr_en, wr_addr, wr_data} !== 62'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b tag=%h wr_en=%b addr=%h data=%h, expected 0",
               busy, done, timeout_err, ready_tag, wr_en, wr_addr, wr_data);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep_2x3();
    logic [31:0] exp_val[6];
    exp_val = '{32'h00, 32'h01, 32'h02, 32'h10, 32'h11, 32'h12};
    clear_knobs();
    row_count = 5'd2; col_count = 6'd3; base_addr = 16'h0100;
    run_sweep(60);
    n_checks++;
    if (nwr !== 6) begin n_errors++; $display("FAIL sweep_nwr: got %0d, expected 6", nwr); end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        int k;
        k = r * 3 + c;
        n_checks++;
        if (wa[k] !== 16'h0100 + 16'(k) || wd[k] !== exp_val[k] || wt[k] !== {4'(r), 5'(c)}) begin
          n_errors++;
          $display("FAIL sweep_write%0d: addr=%h data=%h tag=%h, expected %h %h %h",
                   k, wa[k], wd[k], wt[k], 16'h0100 + 16'(k), exp_val[k], {4'(r), 5'(c)});
        end
      end
    end
    n_checks++;
    if (done_cyc !== 19 || busy_cnt !== 18 || err_at_done !== 1'b0 || rq[0] !== 1) begin
      n_errors++;
      $display("FAIL sweep_timing: done@%0d busy=%0d err=%b req0@%0d, expected 19 18 0 1",
               done_cyc, busy_cnt, err_at_done, rq[0]);
    end
  endtask

  task automatic test_timeout();
    clear_knobs();
    mute_en = 1'b1; mute_tag = {4'd1, 5'd2};
    row_count = 5'd2; col_count = 6'd3; base_addr = 16'h0100;
    run_sweep(80);
    // REQ plus 15 WAIT cycles with ready asserted on the muted tag.
    n_checks++;
    if (max_run !== 16 || done_cyc !== 33 || err_at_done !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_flow: run=%0d done@%0d err=%b, expected 16 33 1", max_run, done_cyc, err_at_done);
    end
    n_checks++;
    if (nwr !== 6 || wa[5] !== 16'h0105 || wd[5] !== 32'h0 || wd[4] !== 32'h11) begin
      n_errors++;
      $display("FAIL timeout_write: nwr=%0d addr=%h data=%h prev=%h, expected 6 0105 0 11",
               nwr, wa[5], wd[5], wd[4]);
    end
    clear_knobs();
    row_count = 5'd1; col_count = 6'd1; base_addr = 16'h0050;
    run_sweep(20);
    n_checks++;
    if (err_at_done !== 1'b0 || done_cyc !== 4 || nwr !== 1 || wa[0] !== 16'h0050) begin
      n_errors++;
      $display("FAIL timeout_clear: err=%b done@%0d nwr=%0d addr=%h, expected 0 4 1 0050",
               err_at_done, done_cyc, nwr, wa[0]);
    end
  endtask

  task automatic test_stall();
    clear_knobs();
    stall_idx = 1; stall_len = 4;
    row_count = 5'd1; col_count = 6'd3; base_addr = 16'h0200;
    run_sweep(40);
    n_checks++;
    if (nwr !== 3 || wa[1] !== 16'h0201 || wd[1] !== 32'h01 || wa[2] !== 16'h0202 || wd[2] !== 32'h02) begin
      n_errors++;
      $display("FAIL stall_writes: nwr=%0d w1=%h/%h w2=%h/%h, expected 3 0201/01 0202/02",
               nwr, wa[1], wd[1], wa[2], wd[2]);
    end
    n_checks++;
    if (rq[2] !== 11 || done_cyc !== 14) begin
      n_errors++;
      $display("FAIL stall_timing: req2@%0d done@%0d, expected 11 14", rq[2], done_cyc);
    end
  endtask

  task automatic test_zero_rows();
    clear_knobs();
    row_count = 5'd0; col_count = 6'd3; base_addr = 16'h0300;
    run_sweep(10);
    n_checks++;
    if (done_cyc !== 1 || busy_cnt !== 1 || nwr !== 0 || rdy_cnt !== 0) begin
      n_errors++;
      $display("FAIL zero_rows: done@%0d busy=%0d nwr=%0d rdy=%0d, expected 1 1 0 0",
               done_cyc, busy_cnt, nwr, rdy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_knobs();
    mute_en = 1'b1; mute_tag = {4'd0, 5'd1}; abort_cyc = 6;
    row_count = 5'd1; col_count = 6'd3; base_addr = 16'h0300;
    run_sweep(20);
    rst = 1'b1;
    clear_knobs();
    row_count = 5'd1; col_count = 6'd1; base_addr = 16'h0400;
    run_sweep(20);
    n_checks++;
    if (nwr !== 1 || wa[0] !== 16'h0400 || wd[0] !== 32'h0 || done_cyc !== 4) begin
      n_errors++;
      $display("FAIL reset_restart: nwr=%0d addr=%h data=%h done@%0d, expected 1 0400 0 4",
               nwr, wa[0], wd[0], done_cyc);
    end
  endtask

  task automatic test_spurious_wrap();
    clear_knobs();
    enable_value = {1'b1, 32'hDEADBEEF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || ready_tag !== 10'd0) begin
        n_errors++;
        $display("FAIL idle_enable: wr_en=%b busy=%b tag=%h, expected 0 0 0", wr_en, busy, ready_tag);
      end
    end
    enable_value = 33'd0;
    restart_cyc = 2;
    row_count = 5'd1; col_count = 6'd2; base_addr = 16'hFFFF;
    run_sweep(30);
    n_checks++;
    if (nwr !== 2 || wa[0] !== 16'hFFFF || wd[0] !== 32'h00 || wa[1] !== 16'h0000 || wd[1] !== 32'h01) begin
      n_errors++;
      $display("FAIL wrap_writes: nwr=%0d w0=%h/%h w1=%h/%h, expected 2 ffff/00 0000/01",
               nwr, wa[0], wd[0], wa[1], wd[1]);
    end
    n_checks++;
    if (done_cyc !== 7) begin
      n_errors++;
      $display("FAIL restart_ignored: done@%0d, expected 7", done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_2x3();
    test_timeout();
    test_stall();
    test_zero_rows();
    test_reset_mid();
    test_spurious_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gon_gather_sequencer.md
Name: gon_gather_sequencer

Overview:
Request-side controller for the GON Y-bus gather path. It walks a rectangular window of PE (row, col) tags in row-major order and drives the bus's {ready, row tag, col id} word for each tag. It captures the returned {enable, value} word and writes each value into the global buffer at a linear address. It sits directly upstream of the Y-bus: it produces the Y-bus ready_tag input and consumes the Y-bus enable_value output.

Parameters:
ID_LEN, 5, width of the column id field
ROW_LEN, 4, width of the row tag field
VALUE_LEN, 32, width of the gathered data value
ADDR_LEN, 16, global-buffer word address width
TIMEOUT, 15, maximum cycles to wait for enable before abandoning a tag (must be at least 1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a sweep when idle
row_count  in  ROW_LEN+1  rows to sweep (0..2^ROW_LEN); latched on start
col_count  in  ID_LEN+1  columns to sweep; latched on start
base_addr  in  ADDR_LEN  first write address; latched on start
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse when the sweep completes
timeout_err  out  1  sticky; set on any timeout, cleared on the next accepted start
ready_tag  out  ROW_LEN+ID_LEN+1  {ready, row tag, col id} to the Y-bus
enable_value  in  VALUE_LEN+1  {enable, value} from the Y-bus
wr_en  out  1  buffer write request
wr_addr  out  ADDR_LEN  write address
wr_data  out  VALUE_LEN  write data
wr_ready  in  1  buffer accepts the write in this cycle (wr_en & wr_ready = transfer)

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; row and col counters 0; timeout_err 0; latched config 0.
- FSM states and transitions:
  - IDLE: start is accepted here only. On start, latch config, clear timeout_err, row=col=0, busy=1. If row_count==0 or col_count==0, go to DONE; otherwise go to REQ.
  - REQ: ready_tag = {1, row[ROW_LEN-1:0], col[ID_LEN-1:0]}; wait counter = 0; go to WAIT.
  - WAIT: ready_tag stays asserted with the same tags.
    - If enable_value[VALUE_LEN]=1, capture the value into the data register and go to WRITE. ready drops in the next cycle.
    - Otherwise the wait counter increments. When the counter reaches TIMEOUT, capture data 0, set timeout_err, and go to WRITE.
  - WRITE: ready_tag = 0; wr_en=1; wr_addr = base + row*col_count + col (truncated to ADDR_LEN, wraps modulo 2^ADDR_LEN); wr_data = captured value.
    - wr_en, wr_addr and wr_data are held stable until wr_ready.
    - On transfer: if col==col_count-1, set col=0 and row+1; otherwise col+1.
    - If row==row_count-1 and col==col_count-1, go to DONE; otherwise go to REQ.
  - DONE: done=1 for one cycle, busy=0 in the same cycle; go to IDLE.
- Latency per tag, best case (enable in the first WAIT cycle, wr_ready high): REQ, WAIT, WRITE = 3 cycles. A full sweep takes 3*R*C + 1 cycles from start to done.
- Address arithmetic: compute incrementally with a running address register (base, +1 per transfer). Because the sweep is row-major, this equals the formula above. No multiplier.
- An enable that arrives outside WAIT is ignored. Its value is not captured.
- start while busy is ignored. A config change while busy has no effect.
- enable and the timeout limit reached in the same cycle: enable wins; no error.
- Reset mid-sweep: immediate return to IDLE. Any pending write is dropped (wr_en low asynchronously).

Decomposition:
- Shared package gon_pkg:
  - Field widths ID_LEN, ROW_LEN, VALUE_LEN.
  - FSM state encoding (IDLE, REQ, WAIT, WRITE, DONE).
  - Helper constants for the ready_tag field positions (ready bit = ROW_LEN+ID_LEN).
- Sub-module gon_tag_counter: a 2-D row/col counter with a running address.
  - Inputs: load, advance, row_count, col_count, base.
  - Outputs: row, col, addr, last.

Test Plan:
- 2x3 sweep, base=0x0100; bus model returns enable with value {row,col} one cycle after ready; wr_ready=1 → six writes to 0x0100..0x0105 with values 00,01,02,10,11,12; ready_tag tags match each write; done pulses at cycle 19 after start; timeout_err=0.
- Tag (1,2) never enabled, TIMEOUT=15 → ready held 15 cycles in WAIT, write of 0 to base+5, timeout_err=1; the sweep still completes. A following start clears timeout_err.
- wr_ready low for 4 cycles on the second write → wr_en/addr/data held constant; no REQ issued during the stall; the next tag follows the transfer.
- row_count=0, start → busy high 1 cycle, done pulse, no ready_tag and no wr_en.
- rst asserted during WAIT of tag (0,1) → outputs 0 immediately; after release and a new 1x1 start, a single write to base.
- Spurious enable while IDLE, plus a start pulse during a sweep → no capture, no write, sweep unaffected; base=0xFFFF with 1x2 writes to 0xFFFF then 0x0000.
